// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bank ALU: command/response encodings,
// packet layouts and the combinational result/status computation.
package alu_pkg;

  localparam int NUM_BANKS = 4;
  localparam int DATA_W    = 32;
  localparam int LATENCY   = 4;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    ADD      = 2'd1,
    MULTIPLY = 2'd2,
    AND      = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    ERROR       = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t    command;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t   response;
    logic [DATA_W-1:0] data;
  } output_packet_t;

  // Truncated result plus overflow status; ERROR is never generated.
  function automatic output_packet_t alu_compute(
    input command_names_t    cmd,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    output_packet_t      r;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    r.response = NO_RESPONSE;
    r.data     = '0;
    case (cmd)
      ADD: begin
        r.data     = sum[DATA_W-1:0];
        r.response = sum[DATA_W] ? OVERFLOW : SUCCESS;
      end
      MULTIPLY: begin
        r.data     = prod[DATA_W-1:0];
        r.response = (prod[2*DATA_W-1:DATA_W] != '0) ? OVERFLOW : SUCCESS;
      end
      AND: begin
        r.data     = a & b;
        r.response = SUCCESS;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_bank.sv
// One ALU channel: computes at capture, then walks a valid bit down vld_pipe so
// the registered result appears exactly LATENCY edges after the capture edge.
module alu_bank
  import alu_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  input_packet_t  input_packet,
  output output_packet_t output_packet
);

  logic [LATENCY-1:0] vld_pipe;
  output_packet_t     res_q;
  logic               busy;
  logic               accept;

  // Busy covers the completion edge too, so the next command lands one edge later.
  assign busy   = |vld_pipe;
  assign accept = !busy && (input_packet.command != NOP);

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_pipe      <= '0;
      res_q         <= '0;
      output_packet <= '0;
    end else begin
      vld_pipe               <= {vld_pipe[LATENCY-2:0], accept};
      output_packet.response <= NO_RESPONSE;
      if (accept)
        res_q <= alu_compute(input_packet.command, input_packet.data1, input_packet.data2);
      if (vld_pipe[LATENCY-1])
        output_packet <= res_q;
    end
  end

endmodule

// File: rtl/alu_4bank.sv
// NUM_BANKS independent ALU channels sharing clock and reset; no cross-bank state.
module alu_4bank
  import alu_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  input_packet_t  [NUM_BANKS-1:0] input_packet,
  output output_packet_t [NUM_BANKS-1:0] output_packet
);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    alu_bank u_bank (
      .clock         (clock),
      .reset         (reset),
      .input_packet  (input_packet[i]),
      .output_packet (output_packet[i])
    );
  end

endmodule

// File: tb/tb_alu_4bank.sv
// Directed and randomized checks of the 4-bank ALU against hand-computed values
// and an independent cycle model sampled on the falling edge.
module tb_alu_4bank;
  import alu_pkg::*;

  logic                           clock;
  logic                           reset;
  input_packet_t  [NUM_BANKS-1:0] input_packet;
  output_packet_t [NUM_BANKS-1:0] output_packet;

  int checks = 0;
  int errors = 0;

  alu_4bank dut (
    .clock         (clock),
    .reset         (reset),
    .input_packet  (input_packet),
    .output_packet (output_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic output_packet_t model(input command_names_t c, input logic [31:0] a,
                                           input logic [31:0] b);
    output_packet_t r;
    logic [32:0] s;
    logic [63:0] p;
    r = '0;
    if (c == ADD) begin
      s = 33'(a) + 33'(b);
      r.data = s[31:0];
      r.response = s[32] ? OVERFLOW : SUCCESS;
    end else if (c == MULTIPLY) begin
      p = 64'(a) * 64'(b);
      r.data = p[31:0];
      r.response = (p[63:32] == 32'd0) ? SUCCESS : OVERFLOW;
    end else if (c == AND) begin
      r.data = a & b;
      r.response = SUCCESS;
    end
    return r;
  endfunction

  // Drive one command for a single cycle starting at the current negedge.
  task automatic issue(input int b, input command_names_t c, input logic [31:0] a,
                       input logic [31:0] d);
    input_packet[b] = '{command: c, data1: a, data2: d};
    @(negedge clock);
    input_packet[b] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    input_packet = '0;
    repeat (2) @(negedge clock);
    for (int b = 0; b < NUM_BANKS; b++) begin
      checks++;
      if (output_packet[b] !== '0) begin
        errors++;
        $display("FAIL reset bank%0d: got %h expected %h", b, output_packet[b], 34'h0);
      end
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Issue each table entry on bank 0 and check: quiet at n+4, pulse at n+5, drop+hold at n+6.
  task automatic run_table(input string name, input command_names_t c,
                           input logic [31:0] a [2], input logic [31:0] d [2],
                           input output_packet_t e [2], input int n);
    output_packet_t held;
    for (int k = 0; k < n; k++) begin
      issue(0, c, a[k], d[k]);
      repeat (3) @(negedge clock);
      checks++;
      if (output_packet[0].response !== NO_RESPONSE) begin
        errors++;
        $display("FAIL %s_early[%0d]: got resp %0d expected %0d", name, k,
                 output_packet[0].response, NO_RESPONSE);
      end
      @(negedge clock);
      checks++;
      if (output_packet[0] !== e[k]) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", name, k, output_packet[0], e[k]);
      end
      @(negedge clock);
      held = e[k];
      held.response = NO_RESPONSE;
      checks++;
      if (output_packet[0] !== held) begin
        errors++;
        $display("FAIL %s_pulse[%0d]: got %h expected %h", name, k, output_packet[0], held);
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] a [2] = '{32'h5, 32'hFFFF_FFFF};
    logic [31:0] d [2] = '{32'h7, 32'h2};
    output_packet_t e [2];
    e[0] = '{response: SUCCESS,  data: 32'h0000_000C};
    e[1] = '{response: OVERFLOW, data: 32'h0000_0001};
    run_table("add", ADD, a, d, e, 2);
  endtask

  task automatic test_multiply();
    logic [31:0] a [2] = '{32'h0001_0000, 32'h1234};
    logic [31:0] d [2] = '{32'h0001_0000, 32'h10};
    output_packet_t e [2];
    e[0] = '{response: OVERFLOW, data: 32'h0000_0000};
    e[1] = '{response: SUCCESS,  data: 32'h0001_2340};
    run_table("mul", MULTIPLY, a, d, e, 2);
  endtask

  task automatic test_and();
    logic [31:0] a [2] = '{32'hF0F0_F0F0, 32'h0};
    logic [31:0] d [2] = '{32'hFF00_FF00, 32'h0};
    output_packet_t e [2];
    e[0] = '{response: SUCCESS, data: 32'hF000_F000};
    e[1] = '0;
    run_table("and", AND, a, d, e, 1);
  endtask

  task automatic test_concurrent();
    output_packet_t e [NUM_BANKS];
    input_packet[0] = '{command: ADD,      data1: 32'h10,        data2: 32'h20};
    input_packet[1] = '{command: MULTIPLY, data1: 32'hFFFF_FFFF, data2: 32'h2};
    input_packet[2] = '{command: AND,      data1: 32'h1234_5678, data2: 32'h0F0F_0F0F};
    input_packet[3] = '{command: ADD,      data1: 32'h8000_0000, data2: 32'h8000_0000};
    e[0] = '{response: SUCCESS,  data: 32'h0000_0030};
    e[1] = '{response: OVERFLOW, data: 32'hFFFF_FFFE};
    e[2] = '{response: SUCCESS,  data: 32'h0204_0608};
    e[3] = '{response: OVERFLOW, data: 32'h0000_0000};
    @(negedge clock);
    input_packet = '0;
    repeat (3) @(negedge clock);
    for (int b = 0; b < NUM_BANKS; b++) begin
      checks++;
      if (output_packet[b].response !== NO_RESPONSE) begin
        errors++;
        $display("FAIL conc_early bank%0d: got resp %0d expected 0", b, output_packet[b].response);
      end
    end
    @(negedge clock);
    for (int b = 0; b < NUM_BANKS; b++) begin
      checks++;
      if (output_packet[b] !== e[b]) begin
        errors++;
        $display("FAIL conc bank%0d: got %h expected %h", b, output_packet[b], e[b]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_busy_ignore();
    output_packet_t e;
    e = '{response: SUCCESS, data: 32'h3};
    issue(1, ADD, 32'h1, 32'h2);
    issue(1, AND, 32'hFF, 32'h0F);
    repeat (3) @(negedge clock);
    checks++;
    if (output_packet[1] !== e) begin
      errors++;
      $display("FAIL busy_first: got %h expected %h", output_packet[1], e);
    end
    e.response = NO_RESPONSE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (output_packet[1] !== e) begin
        errors++;
        $display("FAIL busy_ignored[%0d]: got %h expected %h", k, output_packet[1], e);
      end
    end
  endtask

  task automatic test_reset_midop();
    issue(2, MULTIPLY, 32'h3, 32'h5);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (output_packet[2] !== '0) begin
        errors++;
        $display("FAIL reset_midop[%0d]: got %h expected %h", k, output_packet[2], 34'h0);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_soak();
    int             done_t [NUM_BANKS];
    output_packet_t pend   [NUM_BANKS];
    output_packet_t last   [NUM_BANKS];
    output_packet_t e;
    command_names_t c;
    logic [31:0]    a, d;
    int             r;
    reset = 1'b0;
    input_packet = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      done_t[b] = -1;
      pend[b]   = '0;
      last[b]   = '0;
    end
    for (int t = 0; t < 5000; t++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        e = last[b];
        e.response = NO_RESPONSE;
        if (t == done_t[b]) begin
          e       = pend[b];
          last[b] = pend[b];
        end
        checks++;
        if (output_packet[b] !== e) begin
          errors++;
          $display("FAIL soak t=%0d bank%0d: got %h expected %h", t, b, output_packet[b], e);
        end
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        r = $urandom_range(0, 7);
        c = (r < 4) ? NOP : command_names_t'(r[1:0]);
        a = $urandom;
        d = $urandom;
        if ($urandom_range(0, 1) == 0) a = a >> 17;
        if ($urandom_range(0, 1) == 0) d = d >> 17;
        input_packet[b] = '{command: c, data1: a, data2: d};
        if (c != NOP && t >= done_t[b]) begin
          pend[b]   = model(c, a, d);
          done_t[b] = t + 5;
        end
      end
      @(negedge clock);
    end
    input_packet = '0;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    input_packet = '0;
    test_reset();
    test_add();
    test_multiply();
    test_and();
    test_concurrent();
    test_busy_ignore();
    test_reset_midop();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
